// File: rtl/param_field_extractor_pkg.sv
// Shared types and helpers for the field extractor.
// State encoding and the parameter check helper.
package param_field_extractor_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    HALF,
    FULL
  } pfx_state_e;

  function automatic bit field_fits(
    input int data_w,
    input int lsb,
    input int w
  );
    return (w > 0) && (lsb >= 0) && (lsb + w <= data_w);
  endfunction

endpackage

// File: rtl/param_field_skid.sv
// Two-entry skid buffer with a registered upstream ready.
// Entry "main" drives the output; "skid" absorbs one extra word.
module param_field_skid
  import param_field_extractor_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  pfx_state_e   state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         ready_q;
  logic         in_fire;
  logic         out_fire;

  assign in_fire  = in_valid & ready_q;
  assign out_fire = (state_q != EMPTY) & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = HALF;
          main_d  = in_data;
        end
      end
      HALF: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d = HALF;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // ready is a pure register so upstream never sees a comb path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= (state_d != FULL);
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;

endmodule

// File: rtl/param_field_extractor.sv
// Streaming field extractor: slices a field, adds parity,
// buffers through a skid stage and counts output transfers.
module param_field_extractor
  import param_field_extractor_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int FIELD_LSB = 8,
  parameter int FIELD_W   = 8,
  parameter int PARITY_EN = 1,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FIELD_W-1:0] out_data,
  output logic               out_parity,
  output logic [CNT_W-1:0]   xfer_count
);

  if (!field_fits(DATA_W, FIELD_LSB, FIELD_W) || CNT_W <= 0) begin : g_param_chk
    $fatal(1, "param_field_extractor: field or counter parameters out of range");
  end

  logic [FIELD_W-1:0] field;
  logic               par;
  logic [FIELD_W:0]   buf_out;
  logic               valid_w;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               unused_in;

  assign field     = in_data[FIELD_LSB +: FIELD_W];
  assign unused_in = ^in_data;

  // parity travels with the field so it matches the captured word
  if (PARITY_EN != 0) begin : g_par
    assign par = ^field;
  end else begin : g_nopar
    assign par = 1'b0;
  end

  param_field_skid #(
    .W(FIELD_W + 1)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  ({field, par}),
    .out_valid(valid_w),
    .out_ready(out_ready),
    .out_data (buf_out)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (valid_w && out_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_valid  = valid_w;
  assign out_data   = buf_out[FIELD_W:1];
  assign out_parity = buf_out[0];
  assign xfer_count = cnt_q;

endmodule

// File: tb/tb_param_field_extractor.sv
// Scoreboard bench for param_field_extractor: three instances
// (defaults, 4-bit counter, part-select LSB without parity).
module tb_param_field_extractor;
  import param_field_extractor_pkg::*;

  localparam logic [15:0] SOME_VALUE = 16'h1234;

  typedef struct {
    logic [7:0]  d;
    logic        p;
    logic [15:0] c;
  } exp_t;

  logic clk;
  logic rst;

  logic        in_valid0, in_ready0, out_valid0, out_ready0, out_parity0;
  logic [15:0] in_data0, xfer_count0;
  logic [7:0]  out_data0;

  logic        in_valid1, in_ready1, out_valid1, out_ready1, out_parity1;
  logic [15:0] in_data1;
  logic [3:0]  xfer_count1;
  logic [7:0]  out_data1;

  logic        in_valid2, in_ready2, out_valid2, out_ready2, out_parity2;
  logic [15:0] in_data2, xfer_count2;
  logic [3:0]  out_data2;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t e0, e1, e2;
  logic [15:0] cnt0;

  int total = 0;
  int bad = 0;

  param_field_extractor u0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0),
    .out_data(out_data0), .out_parity(out_parity0),
    .xfer_count(xfer_count0)
  );

  param_field_extractor #(.CNT_W(4)) u1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .out_parity(out_parity1),
    .xfer_count(xfer_count1)
  );

  param_field_extractor #(
    .FIELD_LSB(SOME_VALUE[7:4]),
    .FIELD_W(4),
    .PARITY_EN(0)
  ) u2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_data(out_data2), .out_parity(out_parity2),
    .xfer_count(xfer_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: in_ready never seen, want 1", name);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid0 && out_ready0) begin
      if (q0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL u0_extra: got %0h want none", out_data0);
      end else begin
        e0 = q0.pop_front();
        check("u0_data", 32'(out_data0), 32'(e0.d));
        check("u0_par", 32'(out_parity0), 32'(e0.p));
        check("u0_cnt", 32'(xfer_count0), 32'(e0.c));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid1 && out_ready1) begin
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL u1_extra: got %0h want none", out_data1);
      end else begin
        e1 = q1.pop_front();
        check("u1_data", 32'(out_data1), 32'(e1.d));
        check("u1_par", 32'(out_parity1), 32'(e1.p));
        check("u1_cnt", 32'(xfer_count1), 32'(e1.c[3:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid2 && out_ready2) begin
      if (q2.size() == 0) begin
        total++;
        bad++;
        $display("FAIL u2_extra: got %0h want none", out_data2);
      end else begin
        e2 = q2.pop_front();
        check("u2_data", 32'(out_data2), 32'(e2.d));
        check("u2_par", 32'(out_parity2), 32'(e2.p));
        check("u2_cnt", 32'(xfer_count2), 32'(e2.c));
      end
    end
  end

  task automatic send0(input logic [15:0] d, input logic [7:0] f,
                       input logic p, input bit track);
    int n;
    n = 0;
    if (track) begin
      q0.push_back('{f, p, cnt0});
      cnt0++;
    end
    in_valid0 = 1'b1;
    in_data0  = d;
    forever begin
      @(negedge clk);
      if (in_ready0) break;
      n++;
      if (n > 40) begin
        timeout("u0_accept");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid0 = 1'b0;
  endtask

  task automatic send1(input logic [15:0] d, input logic [7:0] f,
                       input logic [15:0] c);
    int n;
    n = 0;
    q1.push_back('{f, ^f, c});
    in_valid1 = 1'b1;
    in_data1  = d;
    forever begin
      @(negedge clk);
      if (in_ready1) break;
      n++;
      if (n > 40) begin
        timeout("u1_accept");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
  endtask

  task automatic send2(input logic [15:0] d, input logic [3:0] f,
                       input logic [15:0] c);
    int n;
    n = 0;
    q2.push_back('{8'(f), 1'b0, c});
    in_valid2 = 1'b1;
    in_data2  = d;
    forever begin
      @(negedge clk);
      if (in_ready2) break;
      n++;
      if (n > 40) begin
        timeout("u2_accept");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] f;
    rst = 1'b0;
    cnt0 = '0;
    in_valid0 = 0; in_data0 = '0; out_ready0 = 1;
    in_valid1 = 0; in_data1 = '0; out_ready1 = 1;
    in_valid2 = 0; in_data2 = '0; out_ready2 = 1;
    #1 rst = 1'b1;
    #11;
    check("rst_in_ready", 32'(in_ready0), 0);
    check("rst_out_valid", 32'(out_valid0), 0);
    check("rst_out_data", 32'(out_data0), 0);
    check("rst_out_par", 32'(out_parity0), 0);
    check("rst_count", 32'(xfer_count0), 0);

    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_in_ready_low", 32'(in_ready0), 0);
    @(posedge clk);
    #1;
    check("rel_in_ready_high", 32'(in_ready0), 1);

    // single word, 1-cycle latency
    send0(16'h1234, 8'h12, 1'b0, 1);
    check("t1_latency_valid", 32'(out_valid0), 1);
    repeat (2) @(posedge clk);
    #1;
    check("t1_count", 32'(xfer_count0), 1);

    // back-to-back stream
    send0(16'h3400, 8'h34, 1'b1, 1);
    check("t2_in_ready_a", 32'(in_ready0), 1);
    send0(16'h0700, 8'h07, 1'b1, 1);
    check("t2_in_ready_b", 32'(in_ready0), 1);
    repeat (2) @(posedge clk);
    #1;
    check("t2_count", 32'(xfer_count0), 3);

    // fill both entries under backpressure
    out_ready0 = 1'b0;
    send0(16'hAB00, 8'hAB, 1'b1, 1);
    send0(16'hCD00, 8'hCD, 1'b1, 1);
    in_valid0 = 1'b1;
    in_data0  = 16'hEF00;
    repeat (3) @(negedge clk);
    check("t3_full_ready", 32'(in_ready0), 0);
    check("t3_full_valid", 32'(out_valid0), 1);
    check("t3_hold_data", 32'(out_data0), 32'h0AB);
    check("t3_hold_par", 32'(out_parity0), 1);
    check("t3_no_drain", 32'(xfer_count0), 3);
    @(posedge clk);
    #1;
    out_ready0 = 1'b1;
    send0(16'hEF00, 8'hEF, 1'b1, 1);
    repeat (4) @(posedge clk);
    #1;
    check("t3_count", 32'(xfer_count0), 6);
    check("t3_empty", 32'(out_valid0), 0);

    // async reset while FULL discards buffered words
    out_ready0 = 1'b0;
    send0(16'h1100, 8'h11, 1'b0, 0);
    send0(16'hCD00, 8'hCD, 1'b0, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_valid", 32'(out_valid0), 0);
    check("t5_rst_count", 32'(xfer_count0), 0);
    check("t5_rst_ready", 32'(in_ready0), 0);
    check("t5_rst_data", 32'(out_data0), 0);
    cnt0 = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("t5_rel_ready", 32'(in_ready0), 1);
    check("t5_rel_valid", 32'(out_valid0), 0);
    out_ready0 = 1'b1;
    send0(16'h5600, 8'h56, 1'b0, 1);
    repeat (3) @(posedge clk);
    #1;
    check("t5_count", 32'(xfer_count0), 1);

    // 4-bit counter wraps 15 -> 0 -> 1
    for (int i = 0; i < 17; i++) begin
      f = 8'(i);
      send1({f, 8'h00}, f, 16'(i % 16));
    end
    repeat (3) @(posedge clk);
    #1;
    check("u1_wrap_count", 32'(xfer_count1), 1);

    // part-select LSB=3, width 4, parity off
    send2(16'h0078, 4'hF, 16'd0);
    send2(16'h00C0, 4'h8, 16'd1);
    repeat (3) @(posedge clk);
    #1;
    check("u2_count", 32'(xfer_count2), 2);
    check("u2_par_tied", 32'(out_parity2), 0);

    check("fits_14_4", 32'(field_fits(16, 14, 4)), 0);
    check("fits_3_4", 32'(field_fits(16, 3, 4)), 1);

    check("q0_drained", 32'(q0.size()), 0);
    check("q1_drained", 32'(q1.size()), 0);
    check("q2_drained", 32'(q2.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
